// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM constants and measurement state encoding
package pwm_pkg;

  localparam int unsigned CLK_FREQ          = 32_000_000;
  localparam int unsigned PWM_FREQ          = 20_000;
  localparam int unsigned PWM_PERIOD_CYCLES = CLK_FREQ / PWM_FREQ;
  localparam int unsigned CNT_W             = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop input synchronizer with rise/fall detect
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an external PWM line
module pwm_capture #(
  parameter int unsigned CLK_FREQ       = pwm_pkg::CLK_FREQ,
  parameter int unsigned PWM_FREQ       = pwm_pkg::PWM_FREQ,
  parameter int unsigned CNT_W          = pwm_pkg::CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = 2 * (CLK_FREQ / PWM_FREQ),
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  import pwm_pkg::*;

  if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s, rise, fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pwm_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  pwm_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] high_lat, high_lat_nxt;
  logic [CNT_W-1:0] cap_period, cap_period_nxt;
  logic             primed, primed_nxt;
  logic             cap_pend, cap_nxt;
  logic             timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      high_lat   <= '0;
      cap_period <= '0;
      primed     <= 1'b0;
      cap_pend   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      high_lat   <= high_lat_nxt;
      cap_period <= cap_period_nxt;
      primed     <= primed_nxt;
      cap_pend   <= cap_nxt;
    end
  end

  // The first rise out of LOW after IDLE only arms capture, so the first
  // published period is always a complete one started from a clean edge.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    high_lat_nxt   = high_lat;
    cap_period_nxt = cap_period;
    primed_nxt     = primed;
    cap_nxt        = 1'b0;
    timeout_hit    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        cnt_nxt = cnt + CNT_ONE;
        if (fall) begin
          high_lat_nxt = cnt;
          state_nxt    = LOW;
        end else if (cnt == CNT_MAX) begin
          timeout_hit = 1'b1;
        end
      end
      LOW: begin
        cnt_nxt = cnt + CNT_ONE;
        if (rise) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = HIGH;
          if (primed) begin
            cap_nxt        = 1'b1;
            cap_period_nxt = cnt;
          end else begin
            primed_nxt = 1'b1;
          end
        end else if (cnt == CNT_MAX) begin
          timeout_hit = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (timeout_hit) begin
      state_nxt  = IDLE;
      primed_nxt = 1'b0;
      cnt_nxt    = '0;
    end
  end

  // Publish one cycle after capture so both values and the strobe move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_time   <= '0;
      period      <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= cap_pend;
      if (cap_pend) begin
        high_time <= high_lat;
        period    <= cap_period;
        timeout   <= 1'b0;
      end
      if (timeout_hit) begin
        timeout     <= 1'b1;
        stuck_level <= s;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
module tb_pwm_capture;

  localparam int TO = 3200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pwm_in = 1'b0;
  logic [23:0] high_time, period;
  logic        valid, timeout, stuck_level;

  pwm_capture dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .high_time   (high_time),
    .period      (period),
    .valid       (valid),
    .timeout     (timeout),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     h;
    int     p;
    longint t;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     n_rise = 0;
  int     cur_h = 0;
  int     cur_p = 0;
  logic   pin = 1'b0;
  int     hold_ht = 0;
  int     hold_per = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Drive one phase; a rising pin edge ends the previous period in the model.
  task automatic phase(input logic level, input int cycles);
    if (level && !pin) begin
      if (cur_p >= TO) n_rise = 0;
      n_rise++;
      if (n_rise >= 3) sb.push_back('{h: cur_h, p: cur_p, t: cyc});
      cur_h = 0;
      cur_p = 0;
    end
    pin    = level;
    pwm_in = level;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      cur_p++;
      if (level) cur_h++;
    end
  endtask

  task automatic periods(input int h, input int l, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      phase(1'b1, h);
      phase(1'b0, l);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    sb.delete();
    reset  = 1'b0;
    n_rise = pin ? 1 : 0;
    cur_h  = 0;
    cur_p  = 0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_high_time", 32'(high_time), 32'd0);
      chk("rst_period", 32'(period), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_stuck", 32'(stuck_level), 32'd0);
      hold_ht  = 0;
      hold_per = 0;
    end else if (valid) begin
      chk("valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("high_time", 32'(high_time), 32'(e.h));
        chk("period", 32'(period), 32'(e.p));
        chk("latency", 32'(cyc - e.t), 32'd4);
        chk("timeout_clear", 32'(timeout), 32'd0);
        hold_ht  = e.h;
        hold_per = e.p;
      end
    end else begin
      chk("hold_high_time", 32'(high_time), 32'(hold_ht));
      chk("hold_period", 32'(period), 32'(hold_per));
    end
  end

  initial begin
    do_reset();

    periods(400, 1200, 5);
    phase(1'b1, 4000);
    chk("stuck_hi_timeout", 32'(timeout), 32'd1);
    chk("stuck_hi_level", 32'(stuck_level), 32'd1);
    chk("stuck_hi_drain", 32'(sb.size()), 32'd0);

    phase(1'b0, 100);
    periods(400, 1200, 4);
    chk("resume_timeout", 32'(timeout), 32'd0);

    phase(1'b0, 4000);
    chk("stuck_lo_timeout", 32'(timeout), 32'd1);
    chk("stuck_lo_level", 32'(stuck_level), 32'd0);

    periods(1, 1, 4);
    periods(1, 3198, 2);
    periods(1, 3199, 1);
    phase(1'b1, 10);
    chk("p3200_timeout", 32'(timeout), 32'd1);
    chk("p3200_no_valid", 32'(sb.size()), 32'd0);
    phase(1'b0, 10);

    periods(400, 1200, 4);
    chk("clean_timeout", 32'(timeout), 32'd0);

    periods(400, 1200, 1);
    phase(1'b1, 200);
    do_reset();
    phase(1'b1, 197);
    phase(1'b0, 1200);
    periods(400, 1200, 3);
    chk("post_reset_timeout", 32'(timeout), 32'd0);

    periods(400, 1200, 2);
    periods(1200, 400, 3);
    phase(1'b1, 10);
    phase(1'b0, 20);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("final_high_time", 32'(high_time), 32'd1200);
    chk("final_period", 32'(period), 32'd1600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
